// File: rtl/pw_dcache_arbiter_pkg.sv
// Shared types and sizing for the MMU page-walker D-cache port.
// Holds the cache request/response payloads and the issue-port arbiter state encoding.
package pw_dcache_arbiter_pkg;

    localparam int unsigned COMMON_NUM_OF_PW = 2;
    localparam int unsigned NUM_OF_LD_EXE    = 2;
    localparam int unsigned PW_ID_W          = 3;
    localparam int unsigned PADDR_W          = 32;
    localparam int unsigned DATA_W           = 64;

    typedef struct packed {
        logic               valid;
        logic [PW_ID_W-1:0] id;
        logic [PADDR_W-1:0] addr;
    } cache_req_t;

    typedef struct packed {
        logic               valid;
        logic [PW_ID_W-1:0] id;
        logic [DATA_W-1:0]  data;
    } cache_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } pw_arb_state_e;

endpackage

// File: rtl/pw_dcache_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: the first requester at or above ptr wins, otherwise it wraps to index 0.
// The grant is one-hot and purely combinational.
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pw_dcache_arbiter.sv
// Shares the D-cache page-walker issue port among the MMU walkers through a one-entry issue register.
// Responses are routed back by id; the arbiter drains in-flight loads when the TLB is flushed.
module pw_dcache_arbiter
    import pw_dcache_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_OF_PW  = COMMON_NUM_OF_PW,
    parameter  int unsigned NUM_OF_RES = NUM_OF_LD_EXE,
    localparam int unsigned PTR_W      = (NUM_OF_PW > 1) ? $clog2(NUM_OF_PW) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  cache_req_t           pw_req [NUM_OF_PW],
    output logic [NUM_OF_PW-1:0] pw_ready,
    output cache_req_t           req_to_dcache,
    input  logic                 dcache_noroom,
    input  cache_res_t           res_from_dcache [NUM_OF_RES],
    output cache_res_t           pw_res [NUM_OF_PW],
    input  logic                 flush_tlb,
    output logic                 busy
);

    pw_arb_state_e        state_q, state_d;
    cache_req_t           issue_q, issue_d;
    logic [NUM_OF_PW-1:0] os_q, os_d, os_set, os_clr;
    logic [NUM_OF_PW-1:0] held, eligible, grant, routed;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 accept, can_grant, fwd_ok;

    // Per-walker bookkeeping; the walker sitting in the issue register is already in flight.
    always_comb begin
        held     = '0;
        os_set   = '0;
        os_clr   = '0;
        eligible = '0;
        accept   = issue_q.valid && !dcache_noroom;
        for (int unsigned i = 0; i < NUM_OF_PW; i++) begin
            held[i]   = issue_q.valid && (issue_q.id == PW_ID_W'(i));
            os_set[i] = accept && held[i];
            for (int unsigned k = 0; k < NUM_OF_RES; k++) begin
                if (res_from_dcache[k].valid && (res_from_dcache[k].id == PW_ID_W'(i))) begin
                    os_clr[i] = 1'b1;
                end
            end
            eligible[i] = pw_req[i].valid && !os_q[i] && !held[i] && (state_q != DRAIN);
        end
        os_d = (os_q & ~os_clr) | os_set;
    end

    rr_arbiter #(
        .N (NUM_OF_PW)
    ) u_rr (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign can_grant = !flush_tlb && ((state_q == IDLE) || ((state_q == HOLD) && accept));
    assign pw_ready  = (can_grant && reset) ? grant : '0;

    // Next-state: load a granted request, retire an accepted one, or react to a flush.
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|pw_ready) state_d = HOLD;
            end
            HOLD: begin
                if (accept) begin
                    issue_d = '0;
                    state_d = (|pw_ready) ? HOLD : IDLE;
                end
            end
            DRAIN: begin
                if (os_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        for (int unsigned i = 0; i < NUM_OF_PW; i++) begin
            if (pw_ready[i]) begin
                issue_d    = pw_req[i];
                issue_d.id = PW_ID_W'(i);
                ptr_d      = (i == NUM_OF_PW - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        if (flush_tlb && (state_q != DRAIN)) begin
            issue_d = '0;
            state_d = (os_d != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            issue_q <= '0;
            os_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            os_q    <= os_d;
            ptr_q   <= ptr_d;
        end
    end

    assign fwd_ok = !flush_tlb && (state_q != DRAIN);

    // Same-cycle response routing; the lowest matching lane wins.
    always_comb begin
        routed = '0;
        for (int unsigned i = 0; i < NUM_OF_PW; i++) begin
            pw_res[i] = '0;
            for (int unsigned k = 0; k < NUM_OF_RES; k++) begin
                if (!routed[i] && fwd_ok && os_q[i] && res_from_dcache[k].valid &&
                    (res_from_dcache[k].id == PW_ID_W'(i))) begin
                    pw_res[i] = res_from_dcache[k];
                    routed[i] = 1'b1;
                end
            end
        end
    end

    assign req_to_dcache = issue_q;
    assign busy          = issue_q.valid || (|os_q) || (state_q == DRAIN);

endmodule

// File: tb/tb_pw_dcache_arbiter.sv
// Directed-vector bench for pw_dcache_arbiter: two walkers, two response lanes.
// Each vector drives one cycle of inputs and checks the outputs against hand-computed values.
module tb_pw_dcache_arbiter;
    import pw_dcache_arbiter_pkg::*;

    localparam int unsigned NPW  = 2;
    localparam int unsigned NRES = 2;

    logic           clock;
    logic           reset;
    cache_req_t     pw_req [NPW];
    logic [NPW-1:0] pw_ready;
    cache_req_t     req_to_dcache;
    logic           dcache_noroom;
    cache_res_t     res_from_dcache [NRES];
    cache_res_t     pw_res [NPW];
    logic           flush_tlb;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    pw_dcache_arbiter #(
        .NUM_OF_PW  (NPW),
        .NUM_OF_RES (NRES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pw_req          (pw_req),
        .pw_ready        (pw_ready),
        .req_to_dcache   (req_to_dcache),
        .dcache_noroom   (dcache_noroom),
        .res_from_dcache (res_from_dcache),
        .pw_res          (pw_res),
        .flush_tlb       (flush_tlb),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [PADDR_W-1:0] walker_addr(input int unsigned w);
        return 32'hA000_0000 | (32'(w) << 8);
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input int unsigned lane, input logic [2:0] id);
        return 64'hDA7A_0000_0000_0000 | (64'(lane) << 8) | 64'(id);
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then check the settled outputs.
    task automatic apply(input string tag, input bit rst_v,
                         input bit r0, input bit r1, input bit nr, input bit fl,
                         input bit l0v, input logic [2:0] l0id,
                         input bit l1v, input logic [2:0] l1id,
                         input logic [1:0] e_ready, input bit e_iv, input logic [2:0] e_iid,
                         input logic [1:0] e_resv, input bit e_busy);
        @(negedge clock);
        reset                    = rst_v;
        pw_req[0].valid          = r0;
        pw_req[1].valid          = r1;
        dcache_noroom            = nr;
        flush_tlb                = fl;
        res_from_dcache[0].valid = l0v;
        res_from_dcache[0].id    = l0id;
        res_from_dcache[0].data  = lane_data(0, l0id);
        res_from_dcache[1].valid = l1v;
        res_from_dcache[1].id    = l1id;
        res_from_dcache[1].data  = lane_data(1, l1id);
        #1;
        check_val({tag, "/ready"}, 128'(pw_ready), 128'(e_ready));
        check_val({tag, "/iss_v"}, 128'(req_to_dcache.valid), 128'(e_iv));
        if (e_iv) begin
            check_val({tag, "/iss_id"}, 128'(req_to_dcache.id), 128'(e_iid));
            check_val({tag, "/iss_addr"}, 128'(req_to_dcache.addr), 128'(walker_addr(32'(e_iid))));
        end
        check_val({tag, "/res_v"}, 128'({pw_res[1].valid, pw_res[0].valid}), 128'(e_resv));
        for (int i = 0; i < NPW; i++) begin
            if (e_resv[i]) begin
                check_val({tag, "/res_id"}, 128'(pw_res[i].id), 128'(i));
                check_val({tag, "/res_data"}, 128'(pw_res[i].data),
                          128'((l0v && l0id == 3'(i)) ? lane_data(0, l0id) : lane_data(1, l1id)));
            end
        end
        check_val({tag, "/busy"}, 128'(busy), 128'(e_busy));
        if (!rst_v) begin
            check_val({tag, "/req_zero"}, 128'(req_to_dcache), 128'(0));
            check_val({tag, "/res0_zero"}, 128'(pw_res[0]), 128'(0));
            check_val({tag, "/res1_zero"}, 128'(pw_res[1]), 128'(0));
        end
    endtask

    // Two lanes carrying the same id in one cycle is a protocol violation.
    always @(posedge clock) begin
        if (reset) begin
            assert (!(res_from_dcache[0].valid && res_from_dcache[1].valid &&
                      res_from_dcache[0].id == res_from_dcache[1].id))
                else $error("FAIL dup_lane id=%0d", res_from_dcache[0].id);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clock         = 1'b0;
        reset         = 1'b0;
        dcache_noroom = 1'b0;
        flush_tlb     = 1'b0;
        for (int i = 0; i < NPW; i++) begin
            pw_req[i].valid = 1'b0;
            pw_req[i].id    = 3'h7;
            pw_req[i].addr  = walker_addr(32'(i));
        end
        for (int k = 0; k < NRES; k++) res_from_dcache[k] = '0;

        //    tag               rst r0 r1 nr fl  l0v l0id l1v l1id  ready  iv iid resv   busy
        apply("rst",             0, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("s1_grant",        1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("s1_issue",        1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("s1_os_blk_a",     1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("s1_os_blk_b",     1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("s1_resp",         1, 1, 0, 0, 0,  1, 0, 0, 0,  2'b00, 0, 0, 2'b01, 1);
        apply("s1_regrant",      1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("s1_issue2",       1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("lane1_route",     1, 0, 0, 0, 0,  1, 1, 1, 0,  2'b00, 0, 0, 2'b01, 1);
        apply("s1_quiet",        1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("stray_drop",      1, 0, 0, 0, 0,  1, 0, 1, 5,  2'b00, 0, 0, 2'b00, 0);
        apply("rr_g1",           1, 1, 1, 0, 0,  0, 0, 0, 0,  2'b10, 0, 0, 2'b00, 0);
        apply("rr_b2b_g0",       1, 1, 1, 0, 0,  0, 0, 0, 0,  2'b01, 1, 1, 2'b00, 1);
        apply("nr_a",            1, 1, 1, 1, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("nr_b",            1, 1, 1, 1, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("nr_resp1",        1, 1, 1, 1, 0,  1, 1, 0, 0,  2'b00, 1, 0, 2'b10, 1);
        apply("nr_d",            1, 1, 1, 1, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("nr_release_g1",   1, 1, 1, 0, 0,  0, 0, 0, 0,  2'b10, 1, 0, 2'b00, 1);
        apply("rr_os_blk",       1, 1, 1, 0, 0,  0, 0, 0, 0,  2'b00, 1, 1, 2'b00, 1);
        apply("fl_to_drain",     1, 1, 1, 0, 1,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("drain_r0",        1, 1, 1, 0, 0,  1, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("drain_fl_r1",     1, 1, 1, 0, 1,  0, 0, 1, 1,  2'b00, 0, 0, 2'b00, 1);
        apply("drain_exit_g0",   1, 1, 1, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("hold_nr",         1, 0, 1, 1, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("fl_hold_nr",      1, 0, 1, 1, 1,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("fl_hold_idle",    1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("g1",              1, 0, 1, 0, 0,  0, 0, 0, 0,  2'b10, 0, 0, 2'b00, 0);
        apply("fl_accept",       1, 0, 0, 0, 1,  0, 0, 0, 0,  2'b00, 1, 1, 2'b00, 1);
        apply("drain_no_grant",  1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("drain_resp",      1, 1, 0, 0, 0,  1, 1, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("drain_exit",      1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("issue0",          1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("fl_resp_drop",    1, 0, 0, 0, 1,  1, 0, 0, 0,  2'b00, 0, 0, 2'b00, 1);
        apply("fl_resp_idle",    1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("pre_rst_g0",      1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("pre_rst_hold",    1, 1, 0, 1, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("rst_mid_hold",    0, 1, 0, 1, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("rst_held",        0, 1, 0, 0, 0,  0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("rst_stray",       1, 0, 0, 0, 0,  1, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0);
        apply("post_rst_g0",     1, 1, 0, 0, 0,  0, 0, 0, 0,  2'b01, 0, 0, 2'b00, 0);
        apply("post_rst_issue",  1, 0, 0, 0, 0,  0, 0, 0, 0,  2'b00, 1, 0, 2'b00, 1);
        apply("post_rst_resp",   1, 0, 0, 0, 0,  1, 0, 0, 0,  2'b00, 0, 0, 2'b01, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pw_dcache_arbiter.md
# pw_dcache_arbiter

Shares the single page-walker issue port of the D-cache among `NUM_OF_PW` page walkers inside the MMU. Each walker's PTE load is granted round-robin and held in a one-entry issue register until the D-cache accepts it. Returning responses are routed back to the owning walker by id. Tracks one outstanding load per walker and drains in-flight loads cleanly on TLB flush.

## Interface
- `NUM_OF_PW`, default 2, number of requesting page walkers (1..8).
- `NUM_OF_RES`, default `NUM_OF_LD_EXE`, D-cache response lanes scanned per cycle.
- `clock  in  1`: single clock; all state updates on its rising edge.
- `reset  in  1`: asynchronous, active-low; all state cleared while 0.
- `pw_req  in  cache_req_t[NUM_OF_PW]`: walker load requests; level-held until ready.
- `pw_ready  out  1[NUM_OF_PW]`: request accepted this cycle.
- `req_to_dcache  out  cache_req_t`: issue-register contents; `.id` = walker index.
- `dcache_noroom  in  1`: D-cache refuses the presented request this cycle.
- `res_from_dcache  in  cache_res_t[NUM_OF_RES]`: D-cache responses, tagged by `.id`.
- `pw_res  out  cache_res_t[NUM_OF_PW]`: per-walker response, same cycle as arrival.
- `flush_tlb  in  1`: one-cycle pulse; abandon all walker traffic.
- `busy  out  1`: issue register valid, or any outstanding load, or in DRAIN.

## Operation
- States:
  - IDLE: issue register empty.
  - HOLD: issue register valid.
  - DRAIN: flushing; waiting for outstanding loads.
- Per-walker `outstanding[i]` bit:
  - Set when that walker's request leaves the issue register (valid and `!dcache_noroom`).
  - Cleared when a response with `.id == i` arrives.
- Eligible walker: `pw_req[i].valid`, `!outstanding[i]`, and state ≠ DRAIN.
- Grant: round-robin over eligible walkers, starting at `rr_ptr`.
  - Grant is issued in IDLE, or in HOLD on the same cycle the held request is accepted (back-to-back).
  - Granted walker sees `pw_ready[i]=1` for one cycle. Its request is copied into the issue register with `.id` overwritten by `i`.
  - `rr_ptr` ← winner+1, modulo `NUM_OF_PW`.
- HOLD, `dcache_noroom`=1: `req_to_dcache` held bit-stable; no grant.
- Response routing: `pw_res[id]` ← `res_from_dcache[k]` for every valid lane `k` with `id < NUM_OF_PW` and `outstanding[id]`. Otherwise the lane is dropped.
- Two lanes with the same id in one cycle is a protocol error: the lowest lane wins (assertion in bench).
- `flush_tlb`:
  - Issue register invalidated immediately. If it was accepted that same cycle (noroom=0), that request counts as outstanding.
  - Go to DRAIN if any outstanding bit is (or becomes) set, else IDLE.
- DRAIN:
  - `pw_ready`=0; all `pw_res` forced invalid.
  - Responses still clear their outstanding bits.
  - Exit to IDLE the cycle after all bits are 0.
- `flush_tlb` while already in DRAIN: no effect.

## Timing
- Reset values:
  - `pw_ready`=0, `req_to_dcache`='0, `pw_res`='0, `busy`=0.
  - State IDLE, `rr_ptr`=0, all outstanding bits 0.
- Request latency: `pw_ready` in cycle N; `req_to_dcache.valid` from N+1. Minimum one cycle in HOLD.
- Throughput: one request per cycle when `dcache_noroom`=0.
- Response: combinational `res_from_dcache` → `pw_res`, same cycle. Outstanding bit clears at the next edge.
- A walker whose response arrives in cycle M becomes eligible again in M+1, never M.
- Simultaneous flush with response: the response is dropped (not forwarded) but still clears its outstanding bit.
- Reset asserted mid-HOLD or mid-DRAIN: immediate return to reset values; late D-cache responses are dropped because no outstanding bit is set.

## Structure
- Shared package (`CACHE_PROPS`): `cache_req_t`/`cache_res_t` (existing), plus `pw_arb_state_e` {IDLE, HOLD, DRAIN}.
- `NUM_OF_PW` and `NUM_OF_LD_EXE` come from `COMMON_PARAMS`.
- One sub-module: `rr_arbiter` (N-way, ptr input, one-hot grant out), reusable by other MMU arbiters.

## Test plan
- Single walker, noroom=0:
  - pw0 req at cycle 1 → `pw_ready[0]` at 1; `req_to_dcache.valid`, id=0 at 2; response lane0 id=0 at 5 → `pw_res[0].valid` at 5; pw0 regranted no earlier than 6.
- Round-robin with backpressure:
  - pw0 and pw1 requesting continuously, noroom=0 → grants alternate 0,1,0,1.
  - noroom=1 for cycles 3–6 → `req_to_dcache` stable across 3–6; next grant at 7.
- Outstanding block:
  - pw1 has an outstanding load and re-requests → no `pw_ready[1]` until the cycle after its id=1 response.
- Flush during HOLD with noroom=1:
  - Request discarded, never issued; state IDLE next cycle; `busy`=0.
- Flush with two outstanding loads:
  - State DRAIN; both responses arrive → `pw_res` stays invalid.
  - IDLE the cycle after the second response; new requests granted afterwards.
- Async reset at cycle 10, mid-HOLD:
  - All outputs 0 while reset=0.
  - Stray id=0 response after release → dropped, `pw_res[0]` stays invalid.
